// File: rtl/arp_learn_pkg.sv
// Shared definitions for the ARP learner: ARP header constants, where each
// header field sits inside the first 256-bit beat, the layout of one ARP
// table entry, and the state encodings of the parse and writer FSMs.
package arp_learn_pkg;

  // ARP header constant values
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;

  // LSB of each field within beat 0 of the frame
  localparam int ETYPE_LSB = 144;
  localparam int HTYPE_LSB = 128;
  localparam int PTYPE_LSB = 112;
  localparam int HLEN_LSB  = 104;
  localparam int PLEN_LSB  = 96;
  localparam int OPER_LSB  = 80;
  localparam int SHA_LSB   = 32;
  localparam int SPA_LSB   = 0;

  // ARP table entry layout: {16'h0000, mac[47:0], ip[31:0]}
  localparam int MAC_W         = 48;
  localparam int IP_W          = 32;
  localparam int ENTRY_W       = 96;
  localparam int ENTRY_IP_LSB  = 0;
  localparam int ENTRY_MAC_LSB = 32;

  // ARP table geometry
  localparam int TBL_AW    = 5;
  localparam int TBL_DEPTH = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_ACK  = 2'd2
  } wr_state_t;

  typedef enum logic {
    SOP  = 1'b0,
    BODY = 1'b1
  } parse_state_t;

endpackage

// File: rtl/arp_learn_alloc.sv
// Slot allocator for the learner-owned part of the ARP table. Holds a shadow
// copy of the IP (and a valid bit) for every dynamic entry, finds an existing
// entry for an IP so it is refreshed in place, and otherwise hands out slots
// round-robin between FIRST_DYN_ENTRY and the top of the table.
module arp_learn_alloc
  import arp_learn_pkg::*;
#(
  parameter int FIRST_DYN_ENTRY = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [IP_W-1:0]   spa,
  output logic [TBL_AW-1:0] idx,
  input  logic              upd,
  input  logic [TBL_AW-1:0] upd_idx,
  input  logic [IP_W-1:0]   upd_ip
);

  logic [IP_W-1:0]   ip_q    [TBL_DEPTH];
  logic [IP_W-1:0]   ip_d    [TBL_DEPTH];
  logic              valid_q [TBL_DEPTH];
  logic              valid_d [TBL_DEPTH];
  logic [TBL_AW-1:0] ptr_q, ptr_d;
  logic              hit;
  logic [TBL_AW-1:0] hit_idx;

  // Search dynamic entries top-down so the lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TBL_DEPTH - 1; i >= FIRST_DYN_ENTRY; i--) begin
      if (valid_q[i] && (ip_q[i] == spa)) begin
        hit     = 1'b1;
        hit_idx = TBL_AW'(i);
      end
    end
    idx = hit ? hit_idx : ptr_q;
  end

  // Advance the round-robin pointer only when a fresh slot is consumed
  always_comb begin
    ptr_d = ptr_q;
    if (load && !hit) begin
      ptr_d = (ptr_q == TBL_AW'(TBL_DEPTH - 1)) ? TBL_AW'(FIRST_DYN_ENTRY)
                                                : ptr_q + 1'b1;
    end
  end

  // Shadow the IP of an entry once the table has acknowledged its write
  always_comb begin
    ip_d    = ip_q;
    valid_d = valid_q;
    if (upd) begin
      ip_d[upd_idx]    = upd_ip;
      valid_d[upd_idx] = 1'b1;
    end
  end

  // Allocator state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= TBL_AW'(FIRST_DYN_ENTRY);
      for (int i = 0; i < TBL_DEPTH; i++) begin
        ip_q[i]    <= '0;
        valid_q[i] <= 1'b0;
      end
    end else begin
      ptr_q   <= ptr_d;
      ip_q    <= ip_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/arp_learn.sv
// ARP learner: passively watches the router ingress stream, picks out ARP
// replies that arrived on a physical MAC port and writes the sender MAC/IP
// into the ARP table through its single-outstanding write port.
// Build option: define ARP_LEARN_REQUESTS_EN to learn from ARP requests too.
module arp_learn
  import arp_learn_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int FIRST_DYN_ENTRY      = 16
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic                              tbl_wr_req,
  output logic [TBL_AW-1:0]                 tbl_wr_addr,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0]   tbl_wr_data,
  input  logic                              tbl_wr_ack,
  output logic [31:0]                       learn_count,
  output logic [31:0]                       drop_count
);

`ifdef ARP_LEARN_REQUESTS_EN
  localparam bit LEARN_REQUESTS = 1'b1;
`else
  localparam bit LEARN_REQUESTS = 1'b0;
`endif

  parse_state_t      pstate_q, pstate_d;
  logic              stage_ok_q, stage_ok_d;
  logic [MAC_W-1:0]  stage_sha_q, stage_sha_d;
  logic [IP_W-1:0]   stage_spa_q, stage_spa_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic              req_q, req_d;
  logic [TBL_AW-1:0] addr_q, addr_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic [31:0]       learn_q, learn_d;
  logic [31:0]       drop_q, drop_d;

  logic              beat;
  logic [7:0]        src_port;
  logic [15:0]       oper;
  logic              oper_ok;
  logic              qualify;
  logic [MAC_W-1:0]  beat_sha;
  logic [IP_W-1:0]   beat_spa;
  logic              commit;
  logic [MAC_W-1:0]  commit_sha;
  logic [IP_W-1:0]   commit_spa;
  logic              load;
  logic              ack_evt;
  logic [TBL_AW-1:0] alloc_idx;
  logic              unused_ok;

  assign beat      = S_AXIS_TVALID & S_AXIS_TREADY;
  assign src_port  = S_AXIS_TUSER[SRC_PORT_POS +: 8];
  assign oper      = S_AXIS_TDATA[OPER_LSB +: 16];
  assign beat_sha  = S_AXIS_TDATA[SHA_LSB +: MAC_W];
  assign beat_spa  = S_AXIS_TDATA[SPA_LSB +: IP_W];
  assign unused_ok = ^{S_AXIS_TDATA, S_AXIS_TUSER};

  // Decide whether the current beat is the header of a learnable ARP frame
  always_comb begin
    oper_ok = (oper == ARP_OPER_REP) || (LEARN_REQUESTS && (oper == ARP_OPER_REQ));
    qualify = (S_AXIS_TDATA[ETYPE_LSB +: 16] == ETHERTYPE_ARP)
           && (S_AXIS_TDATA[HTYPE_LSB +: 16] == ARP_HTYPE_ETH)
           && (S_AXIS_TDATA[PTYPE_LSB +: 16] == ARP_PTYPE_IPV4)
           && (S_AXIS_TDATA[HLEN_LSB  +: 8]  == ARP_HLEN_ETH)
           && (S_AXIS_TDATA[PLEN_LSB  +: 8]  == ARP_PLEN_IPV4)
           && oper_ok
           && (|(src_port & 8'h55))
           && !(|(src_port & 8'hAA));
  end

  // Track frame boundaries, stage the sender fields and raise commit on TLAST
  always_comb begin
    pstate_d    = pstate_q;
    stage_ok_d  = stage_ok_q;
    stage_sha_d = stage_sha_q;
    stage_spa_d = stage_spa_q;
    commit      = 1'b0;
    commit_sha  = stage_sha_q;
    commit_spa  = stage_spa_q;
    case (pstate_q)
      SOP: begin
        if (beat) begin
          stage_ok_d = qualify;
          if (qualify) begin
            stage_sha_d = beat_sha;
            stage_spa_d = beat_spa;
          end
          if (S_AXIS_TLAST) begin
            commit     = qualify;
            commit_sha = beat_sha;
            commit_spa = beat_spa;
          end else begin
            pstate_d = BODY;
          end
        end
      end
      BODY: begin
        if (beat && S_AXIS_TLAST) begin
          commit     = stage_ok_q;
          stage_ok_d = 1'b0;
          pstate_d   = SOP;
        end
      end
      default: pstate_d = SOP;
    endcase
  end

  assign load    = commit && (wr_state_q == W_IDLE);
  assign ack_evt = (wr_state_q == W_ACK) && tbl_wr_ack;

  arp_learn_alloc #(
    .FIRST_DYN_ENTRY (FIRST_DYN_ENTRY)
  ) u_alloc (
    .clk     (AXI_ACLK),
    .rst     (AXI_RESET),
    .load    (load),
    .spa     (commit_spa),
    .idx     (alloc_idx),
    .upd     (ack_evt),
    .upd_idx (addr_q),
    .upd_ip  (data_q[ENTRY_IP_LSB +: IP_W])
  );

  // Writer: one request pulse per load, then hold the entry until acknowledged
  always_comb begin
    wr_state_d = wr_state_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    learn_d    = learn_q;
    drop_d     = drop_q;
    case (wr_state_q)
      W_IDLE: begin
        if (load) begin
          wr_state_d                     = W_REQ;
          req_d                          = 1'b1;
          addr_d                         = alloc_idx;
          data_d                         = '0;
          data_d[ENTRY_MAC_LSB +: MAC_W] = commit_sha;
          data_d[ENTRY_IP_LSB +: IP_W]   = commit_spa;
        end
      end
      W_REQ: wr_state_d = W_ACK;
      W_ACK: begin
        if (tbl_wr_ack) begin
          wr_state_d = W_IDLE;
          if (learn_q != 32'hFFFF_FFFF) learn_d = learn_q + 32'd1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (commit && (wr_state_q != W_IDLE) && (drop_q != 32'hFFFF_FFFF)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  // State and output registers for both FSMs
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      pstate_q    <= SOP;
      stage_ok_q  <= 1'b0;
      stage_sha_q <= '0;
      stage_spa_q <= '0;
      wr_state_q  <= W_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      learn_q     <= '0;
      drop_q      <= '0;
    end else begin
      pstate_q    <= pstate_d;
      stage_ok_q  <= stage_ok_d;
      stage_sha_q <= stage_sha_d;
      stage_spa_q <= stage_spa_d;
      wr_state_q  <= wr_state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      learn_q     <= learn_d;
      drop_q      <= drop_d;
    end
  end

  assign tbl_wr_req  = req_q;
  assign tbl_wr_addr = addr_q;
  assign tbl_wr_data = data_q;
  assign learn_count = learn_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_arp_learn.sv
// Self-checking bench for arp_learn: a table of ARP/non-ARP frames with the
// expected table write for each, plus hand-written sequences for dropping on
// a busy writer, reset in the middle of a write, and round-robin wrap.
module tb_arp_learn;

`ifdef ARP_LEARN_REQUESTS_EN
  localparam bit LEARN_REQ = 1'b1;
`else
  localparam bit LEARN_REQ = 1'b0;
`endif

  logic         AXI_ACLK;
  logic         AXI_RESET;
  logic [255:0] S_AXIS_TDATA;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TREADY;
  logic         S_AXIS_TLAST;
  logic         tbl_wr_req;
  logic [4:0]   tbl_wr_addr;
  logic [95:0]  tbl_wr_data;
  logic         tbl_wr_ack;
  logic [31:0]  learn_count;
  logic [31:0]  drop_count;

  typedef struct {
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [7:0]  src;
    int          nbeats;
    logic        ready;
    logic        exp_wr;
    logic [4:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [95:0] data;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[16];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ack_delay = 1;
  bit    ack_busy = 0;
  int    exp_learn = 0;
  int    exp_drop = 0;

  arp_learn dut (
    .AXI_ACLK      (AXI_ACLK),
    .AXI_RESET     (AXI_RESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .tbl_wr_req    (tbl_wr_req),
    .tbl_wr_addr   (tbl_wr_addr),
    .tbl_wr_data   (tbl_wr_data),
    .tbl_wr_ack    (tbl_wr_ack),
    .learn_count   (learn_count),
    .drop_count    (drop_count)
  );

  initial begin
    AXI_ACLK = 1'b0;
    forever #5 AXI_ACLK = ~AXI_ACLK;
  end

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Table-side model: acknowledge each request after ack_delay cycles
  initial begin
    tbl_wr_ack = 1'b0;
    forever begin
      @(negedge AXI_ACLK);
      if (tbl_wr_req === 1'b1) begin
        ack_busy = 1'b1;
        repeat (ack_delay) @(negedge AXI_ACLK);
        tbl_wr_ack = 1'b1;
        @(negedge AXI_ACLK);
        tbl_wr_ack = 1'b0;
        ack_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every request cycle must match the oldest expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge AXI_ACLK);
      if (tbl_wr_req === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_write: request to addr %0d data %0h, expected no request",
                   tbl_wr_addr, tbl_wr_data);
        end else begin
          e = sb.pop_front();
          checkOutput("wr_addr", 96'(tbl_wr_addr), 96'(e.addr));
          checkOutput("wr_data", tbl_wr_data, e.data);
        end
      end
    end
  end

  function automatic vec_t good(input logic [47:0] sha, input logic [31:0] spa,
                                input logic [7:0] src, input int nbeats,
                                input logic exp_wr, input logic [4:0] exp_addr);
    vec_t v;
    v.etype = 16'h0806; v.htype = 16'h0001; v.ptype = 16'h0800;
    v.hlen = 8'd6; v.plen = 8'd4; v.oper = 16'h0002;
    v.sha = sha; v.spa = spa; v.src = src; v.nbeats = nbeats;
    v.ready = 1'b1; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
    return v;
  endfunction

  function automatic logic [255:0] beat0(input vec_t v);
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d[159:0] = {v.etype, v.htype, v.ptype, v.hlen, v.plen, v.oper, v.sha, v.spa};
    return d;
  endfunction

  // Drive one frame, then check the request pulse the cycle after its TLAST
  task automatic sendFrame(input vec_t v, input logic exp_req);
    for (int b = 0; b < v.nbeats; b++) begin
      @(negedge AXI_ACLK);
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TREADY = v.ready;
      S_AXIS_TLAST  = (b == v.nbeats - 1);
      S_AXIS_TDATA  = (b == 0) ? beat0(v)
                    : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      S_AXIS_TUSER  = {$urandom, $urandom, $urandom, $urandom};
      S_AXIS_TUSER[23:16] = v.src;
    end
    @(negedge AXI_ACLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b1;
    checkOutput("req_latency", 96'(tbl_wr_req), 96'(exp_req));
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge AXI_ACLK);
      if (sb.size() == 0 && !ack_busy) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL idle_timeout: %0d writes still outstanding after 100 cycles, expected 0", sb.size());
    end
    repeat (2) @(negedge AXI_ACLK);
  endtask

  task automatic pushExp(input vec_t v);
    exp_t e;
    e.addr = v.exp_addr;
    e.data = {16'h0000, v.sha, v.spa};
    sb.push_back(e);
    exp_learn++;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_learn"}, 96'(learn_count), 96'(exp_learn));
    checkOutput({tag, "_drop"},  96'(drop_count),  96'(exp_drop));
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.exp_wr) pushExp(v);
    sendFrame(v, v.exp_wr);
    waitIdle();
    checkCounters("vec");
  endtask

  task automatic pulseReset();
    @(negedge AXI_ACLK);
    AXI_RESET = 1'b1;
    repeat (2) @(negedge AXI_ACLK);
    AXI_RESET = 1'b0;
    exp_learn = 0;
    exp_drop = 0;
  endtask

  initial begin
    vec_t v;
    vec_t w;

    AXI_RESET     = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TUSER  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TREADY = 1'b1;
    S_AXIS_TLAST  = 1'b0;

    // Vector table: frame fields plus the write each one should produce
    vecs[0]  = good(48'h001122334455, 32'h0A000001, 8'h01, 2, 1'b1, 5'd16);
    vecs[1]  = good(48'hAABBCCDDEEFF, 32'h0A000001, 8'h01, 2, 1'b1, 5'd16);
    vecs[2]  = good(48'h000000000011, 32'h0A000011, 8'h01, 2, 1'b0, 5'd0);
    vecs[2].etype = 16'h0800;
    vecs[3]  = good(48'h000000000012, 32'h0A000012, 8'h02, 2, 1'b0, 5'd0);
    vecs[4]  = good(48'h0A0B0C0D0E0F, 32'h0A000002, 8'h04, 1, 1'b1, 5'd17);
    vecs[5]  = good(48'h102030405060, 32'h0A000003, 8'h05, 3, 1'b1, 5'd18);
    vecs[6]  = good(48'h000000000013, 32'h0A000013, 8'h03, 1, 1'b0, 5'd0);
    vecs[7]  = good(48'h000000000014, 32'h0A000014, 8'h01, 2, 1'b0, 5'd0);
    vecs[7].htype = 16'h0002;
    vecs[8]  = good(48'h000000000015, 32'h0A000015, 8'h01, 2, 1'b0, 5'd0);
    vecs[8].hlen = 8'd5;
    vecs[9]  = good(48'h000000000016, 32'h0A000016, 8'h01, 2, 1'b0, 5'd0);
    vecs[9].oper = 16'h0003;
    vecs[10] = good(48'h000000000017, 32'h0A000017, 8'h01, 1, 1'b0, 5'd0);
    vecs[10].ready = 1'b0;
    vecs[11] = good(48'h665544332211, 32'h0A000002, 8'h10, 1, 1'b1, 5'd17);
    vecs[12] = good(48'h000000000018, 32'h0A000018, 8'h00, 2, 1'b0, 5'd0);
    vecs[13] = good(48'h000000000019, 32'h0A000019, 8'h01, 2, 1'b0, 5'd0);
    vecs[13].ptype = 16'h86DD;
    vecs[14] = good(48'h00000000001A, 32'h0A00001A, 8'h01, 2, 1'b0, 5'd0);
    vecs[14].plen = 8'd16;
    vecs[15] = good(48'hDEADBEEF0001, 32'h0A000004, 8'h40, 2, 1'b1, 5'd19);

    // Reset state
    repeat (3) @(negedge AXI_ACLK);
    checkOutput("rst_req",   96'(tbl_wr_req),  96'd0);
    checkOutput("rst_addr",  96'(tbl_wr_addr), 96'd0);
    checkOutput("rst_data",  tbl_wr_data,      96'd0);
    checkOutput("rst_learn", 96'(learn_count), 96'd0);
    checkOutput("rst_drop",  96'(drop_count),  96'd0);
    AXI_RESET = 1'b0;
    @(negedge AXI_ACLK);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

    // Second frame ends while the first write waits for its ack: dropped
    $display("[TB] busy writer drop");
    ack_delay = 10;
    v = good(48'h111111111111, 32'h0A000005, 8'h01, 2, 1'b1, 5'd20);
    w = good(48'h222222222222, 32'h0A000006, 8'h01, 2, 1'b0, 5'd0);
    pushExp(v);
    sendFrame(v, 1'b1);
    sendFrame(w, 1'b0);
    exp_drop++;
    waitIdle();
    checkCounters("drop");
    ack_delay = 1;

    // Reset while the writer is waiting for an ack clears everything at once
    $display("[TB] reset during write");
    ack_delay = 20;
    v = good(48'h333333333333, 32'h0A000007, 8'h01, 2, 1'b1, 5'd21);
    pushExp(v);
    sendFrame(v, 1'b1);
    repeat (3) @(negedge AXI_ACLK);
    AXI_RESET = 1'b1;
    #1;
    checkOutput("async_req",   96'(tbl_wr_req),  96'd0);
    checkOutput("async_addr",  96'(tbl_wr_addr), 96'd0);
    checkOutput("async_data",  tbl_wr_data,      96'd0);
    checkOutput("async_learn", 96'(learn_count), 96'd0);
    checkOutput("async_drop",  96'(drop_count),  96'd0);
    @(negedge AXI_ACLK);
    AXI_RESET = 1'b0;
    exp_learn = 0;
    exp_drop = 0;
    repeat (30) @(negedge AXI_ACLK);
    ack_delay = 1;

    // ARP request learns only when request learning is built in
    v = good(48'h020000000001, 32'h0A000101, 8'h01, 2, LEARN_REQ, 5'd16);
    v.oper = 16'h0001;
    applyStimulus(v);
    v = good(48'h020000000002, 32'h0A000102, 8'h04, 2, 1'b1, LEARN_REQ ? 5'd17 : 5'd16);
    applyStimulus(v);

    // Seventeen distinct IPs after reset: the last one wraps to the first slot
    $display("[TB] round-robin wrap");
    pulseReset();
    for (int i = 0; i < 17; i++) begin
      v = good(48'h030000000000 + 48'(i), 32'h0A000200 + 32'(i), 8'h01, 1, 1'b1, 5'(16 + (i % 16)));
      if (v.exp_wr) pushExp(v);
      sendFrame(v, 1'b1);
      waitIdle();
    end
    checkCounters("wrap");

    checkOutput("sb_drained", 96'(sb.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
